// File: rtl/icache_rd_bridge_if.sv
`default_nettype none
// ============================================================================
// icache_rd_bridge_if : icache read port plus AXI4 AR/R channels.
// Revision: 1.0
// ============================================================================
interface icache_rd_bridge_if;
    logic         rd_req;
    logic         rd_uncache;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [127:0] ret_data;

    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [3:0]   arcache;
    logic         arvalid;
    logic         arready;

    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    // Bridge side: answers the cache, masters the AXI read channels.
    modport master (
        input  rd_req, rd_uncache, rd_addr,
        output rd_rdy, ret_valid, ret_data,
        output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output rd_req, rd_uncache, rd_addr,
        input  rd_rdy, ret_valid, ret_data,
        input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/icache_rd_bridge.sv
`default_nettype none
// ============================================================================
// icache_rd_bridge : one icache refill/uncached read -> one AXI4 read burst.
// Revision: 1.0
// ============================================================================
module icache_rd_bridge #(
    parameter logic [3:0] AXI_ID        = 4'd0,
    parameter int         LINE_WORD_NUM = 4,
    parameter int         DATA_WIDTH    = 32
) (
    input  logic               clk_g,
    input  logic               resetn,
    icache_rd_bridge_if.master bus
);
    localparam int                 c_LINE_W     = LINE_WORD_NUM * DATA_WIDTH;
    localparam int                 c_CNT_W      = $clog2(LINE_WORD_NUM + 1);
    localparam logic [c_CNT_W-1:0] c_LINE_WORDS = c_CNT_W'(LINE_WORD_NUM);
    localparam logic [7:0]         c_LINE_LEN   = 8'(LINE_WORD_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_addr;
    logic                 r_uncache;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_LINE_W-1:0]  r_data;

    logic                 w_rd_rdy;
    logic                 w_arvalid;
    logic                 w_rready;
    logic                 w_ret_valid;
    logic                 w_accept;
    logic                 w_beat;

    // rid and rresp carry nothing this bridge acts on.
    logic                 w_unused_ok;
    assign w_unused_ok = &{1'b0, bus.rid, bus.rresp};

    always_ff @(posedge clk_g or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_rdy    = 1'b0;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        w_ret_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rd_rdy = bus.rd_req;
                if (bus.rd_req) w_state_nxt = S_AR;
            end
            S_AR: begin
                w_arvalid = 1'b1;
                if (bus.arready) w_state_nxt = S_R;
            end
            S_R: begin
                w_rready = 1'b1;
                if (bus.rvalid && bus.rlast) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_ret_valid = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && bus.rd_req;
    assign w_beat   = (r_state == S_R) && bus.rvalid;

    // Request latch and line assembly; the counter saturates so beats past
    // the line length are dropped instead of wrapping onto word 0.
    always_ff @(posedge clk_g or negedge resetn) begin
        if (!resetn) begin
            r_addr    <= 32'd0;
            r_uncache <= 1'b0;
            r_cnt     <= '0;
            r_data    <= '0;
        end else if (w_accept) begin
            r_addr    <= bus.rd_addr;
            r_uncache <= bus.rd_uncache;
            r_cnt     <= '0;
            r_data    <= '0;
        end else if (w_beat) begin
            if (r_uncache) begin
                r_data[c_LINE_W-1 -: DATA_WIDTH] <= bus.rdata;
            end else if (r_cnt < c_LINE_WORDS) begin
                for (int i = 0; i < LINE_WORD_NUM; i++) begin
                    if (r_cnt == c_CNT_W'(i)) begin
                        r_data[i*DATA_WIDTH +: DATA_WIDTH] <= bus.rdata;
                    end
                end
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.rd_rdy    = w_rd_rdy;
    assign bus.ret_valid = w_ret_valid;
    assign bus.ret_data  = r_data;

    assign bus.arid      = AXI_ID;
    assign bus.araddr    = r_addr;
    assign bus.arlen     = r_uncache ? 8'd0 : c_LINE_LEN;
    assign bus.arsize    = 3'b010;
    assign bus.arburst   = 2'b01;
    assign bus.arcache   = r_uncache ? 4'b0000 : 4'b1111;
    assign bus.arvalid   = w_arvalid;
    assign bus.rready    = w_rready;
endmodule
`default_nettype wire

// File: tb/tb_icache_rd_bridge.sv
`default_nettype none
// ============================================================================
// tb_icache_rd_bridge : directed stimulus with a queue-based scoreboard.
// Revision: 1.0
// ============================================================================
module tb_icache_rd_bridge;
    logic clk_g  = 1'b0;
    logic resetn = 1'b0;
    always #5 clk_g = ~clk_g;

    icache_rd_bridge_if bus();

    icache_rd_bridge #(
        .AXI_ID        (4'd0),
        .LINE_WORD_NUM (4),
        .DATA_WIDTH    (32)
    ) dut (
        .clk_g  (clk_g),
        .resetn (resetn),
        .bus    (bus.master)
    );

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } ret_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  cache;
    } ar_exp_t;

    ret_exp_t ret_q[$];
    ar_exp_t  ar_q[$];

    int n_chk        = 0;
    int n_pass       = 0;
    int cyc          = 0;
    int last_ret_cyc = -100;
    bit busy         = 1'b0;
    bit prev_stall   = 1'b0;
    logic [43:0] prev_ar = '0;

    always @(posedge clk_g) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: got event expected none", name);
    endtask

    task automatic tick();
        @(posedge clk_g);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents ret_valid or an AR handshake.
    always @(negedge clk_g) begin : mon
        ret_exp_t e;
        ar_exp_t  a;
        if (!resetn) begin
            busy       = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (bus.ret_valid) begin
                last_ret_cyc = cyc;
                busy         = 1'b0;
                if (ret_q.size() == 0) begin
                    fail_now("unexpected_ret_valid");
                end else begin
                    e = ret_q.pop_front();
                    check("ret_data", bus.ret_data, e.data);
                    check("ret_latency", 128'(cyc), 128'(e.cyc));
                end
            end
            if (bus.rd_rdy) begin
                check("rd_rdy_while_busy", 128'(busy), 128'(0));
                busy = 1'b1;
            end
            if (bus.arvalid) begin
                if (prev_stall)
                    check("ar_stable", 128'({bus.araddr, bus.arlen, bus.arcache}), 128'(prev_ar));
                if (bus.arready) begin
                    if (ar_q.size() == 0) begin
                        fail_now("unexpected_ar");
                    end else begin
                        a = ar_q.pop_front();
                        check("ar_fields",
                              128'({bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arcache}),
                              128'({4'h0, a.addr, a.len, 3'b010, 2'b01, a.cache}));
                    end
                end
                prev_stall = !bus.arready;
                prev_ar    = {bus.araddr, bus.arlen, bus.arcache};
            end else begin
                if (prev_stall) fail_now("arvalid_dropped_before_handshake");
                prev_stall = 1'b0;
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input bit unc, input logic [127:0] exp_data,
                         input int lat, input bit expect_ret, input bit hold, output int acc);
        bit accepted;
        ar_exp_t  a;
        ret_exp_t e;
        accepted       = 1'b0;
        acc            = -1;
        bus.rd_req     = 1'b1;
        bus.rd_addr    = addr;
        bus.rd_uncache = unc;
        for (int k = 0; k < 60 && !accepted; k++) begin
            @(negedge clk_g);
            if (bus.rd_rdy) begin
                accepted = 1'b1;
                acc      = cyc;
                a.addr   = addr;
                a.len    = unc ? 8'd0 : 8'd3;
                a.cache  = unc ? 4'h0 : 4'hF;
                ar_q.push_back(a);
                if (expect_ret) begin
                    e.data = exp_data;
                    e.cyc  = acc + lat;
                    ret_q.push_back(e);
                end
            end
            tick();
        end
        if (!accepted) fail_now("req_accept_timeout");
        if (!hold) bus.rd_req = 1'b0;
    endtask

    task automatic axi_serve(input int ar_wait, input int gap, input int n, input bit last_on_final,
                             input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] d3, input logic [31:0] d4);
        logic [31:0] d[5];
        bit seen;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3; d[4] = d4;
        seen        = 1'b0;
        bus.arready = (ar_wait == 0);
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk_g);
            if (bus.arvalid) seen = 1'b1;
        end
        if (!seen) begin
            fail_now("arvalid_timeout");
        end else begin
            repeat (ar_wait) tick();
            bus.arready = 1'b1;
            tick();
            bus.arready = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (i > 0) begin
                    repeat (gap) begin
                        bus.rvalid = 1'b0;
                        bus.rlast  = 1'b0;
                        tick();
                    end
                end
                bus.rvalid = 1'b1;
                bus.rdata  = d[i];
                bus.rlast  = last_on_final && (i == n - 1);
                tick();
            end
            bus.rvalid = 1'b0;
            bus.rlast  = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc1;
        int acc2;
        bus.rd_req = 0; bus.rd_uncache = 0; bus.rd_addr = '0;
        bus.arready = 0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0;
        bus.rlast = 0; bus.rvalid = 0;

        repeat (3) tick();
        check("rst_arvalid",   128'(bus.arvalid),   128'(0));
        check("rst_rready",    128'(bus.rready),    128'(0));
        check("rst_ret_valid", 128'(bus.ret_valid), 128'(0));
        check("rst_ret_data",  bus.ret_data,        128'(0));
        check("rst_araddr",    128'(bus.araddr),    128'(0));
        check("rst_rd_rdy",    128'(bus.rd_rdy),    128'(0));
        resetn = 1'b1;
        repeat (2) tick();

        // Cached refill, zero-wait
        fork
            issue(32'h1FC0_0010, 1'b0, 128'h44444444_33333333_22222222_11111111, 6, 1'b1, 1'b0, acc1);
            axi_serve(0, 0, 4, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h0);
        join
        tick();

        // Uncached single word
        fork
            issue(32'hBFC0_0004, 1'b1, 128'hDEADBEEF_00000000_00000000_00000000, 3, 1'b1, 1'b0, acc1);
            axi_serve(0, 0, 1, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0);
        join
        tick();

        // AR stalled 5 cycles, 2 idle cycles between beats
        fork
            issue(32'h0000_1000, 1'b0, 128'hA0000004_A0000003_A0000002_A0000001, 17, 1'b1, 1'b0, acc1);
            axi_serve(5, 2, 4, 1'b1, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'h0);
        join
        tick();

        // Early rlast on beat 2
        fork
            issue(32'h0000_2000, 1'b0, 128'h00000000_00000000_BBBB0000_AAAA0000, 4, 1'b1, 1'b0, acc1);
            axi_serve(0, 0, 2, 1'b1, 32'hAAAA0000, 32'hBBBB0000, 32'h0, 32'h0, 32'h0);
        join
        tick();

        // Fifth beat past the line length is discarded
        fork
            issue(32'h0000_3000, 1'b0, 128'h04040404_03030303_02020202_01010101, 7, 1'b1, 1'b0, acc1);
            axi_serve(0, 0, 5, 1'b1, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 32'h05050505);
        join
        tick();

        // Back-to-back with rd_req held high
        fork
            begin
                issue(32'h0000_4000, 1'b0, 128'h10000004_10000003_10000002_10000001, 6, 1'b1, 1'b1, acc1);
                issue(32'h0000_4010, 1'b0, 128'h20000004_20000003_20000002_20000001, 6, 1'b1, 1'b0, acc2);
                check("b2b_accept_cycle", 128'(acc2), 128'(last_ret_cyc + 1));
                check("b2b_accept_gap",   128'(acc2 - acc1), 128'(7));
            end
            begin
                axi_serve(0, 0, 4, 1'b1, 32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004, 32'h0);
                axi_serve(0, 0, 4, 1'b1, 32'h20000001, 32'h20000002, 32'h20000003, 32'h20000004, 32'h0);
            end
        join
        tick();

        // Reset after two beats of a refill
        fork
            issue(32'h0000_5000, 1'b0, 128'h0, 0, 1'b0, 1'b0, acc1);
            axi_serve(0, 0, 2, 1'b0, 32'hCAFE0001, 32'hCAFE0002, 32'h0, 32'h0, 32'h0);
        join
        check("pre_rst_rready", 128'(bus.rready), 128'(1));
        resetn = 1'b0;
        #1;
        check("mid_rst_arvalid",   128'(bus.arvalid),   128'(0));
        check("mid_rst_rready",    128'(bus.rready),    128'(0));
        check("mid_rst_ret_valid", 128'(bus.ret_valid), 128'(0));
        check("mid_rst_ret_data",  bus.ret_data,        128'(0));
        repeat (2) tick();
        resetn = 1'b1;
        repeat (2) tick();

        // Recovery transaction
        fork
            issue(32'h0000_6000, 1'b0, 128'h60000004_60000003_60000002_60000001, 6, 1'b1, 1'b0, acc1);
            axi_serve(0, 0, 4, 1'b1, 32'h60000001, 32'h60000002, 32'h60000003, 32'h60000004, 32'h0);
        join
        repeat (4) tick();

        check("ret_q_drained", 128'(ret_q.size()), 128'(0));
        check("ar_q_drained",  128'(ar_q.size()),  128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
